// File: rtl/adc_hex_reporter.sv
// adc_hex_reporter
//   Formats multi-channel ADC frames as ASCII hex lines for a byte-wide UART
//   transmitter. Each line holds the channels in order 0..NUM_CH-1 as
//   DATA_W/4 uppercase hex digits, MSB nibble first, separated by SEP and
//   terminated by CR LF. A rising edge on i_error queues a one-off "E\r\n"
//   report. A one-deep pending buffer absorbs a frame that arrives while a
//   line is in flight. Later frames overwrite the buffer and are counted as
//   overruns.
//
// Parameters
//   DATA_W  sample width in bits (multiple of 4, 4..32)
//   NUM_CH  channels per frame (1..8)
//   SEP     field separator character
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   i_frame        channel k at [k*DATA_W +: DATA_W]
//   i_frame_valid  one-cycle frame strobe
//   i_error        ADC driver error level
//   tx_data        byte to uart_tx, stable while tx_start is high
//   tx_start       one-cycle start strobe to uart_tx
//   tx_busy        uart_tx busy flag
//   o_busy         high while a line is being emitted
//   o_dropped      one-cycle pulse when the pending frame is overwritten
//   o_overrun_cnt  saturating count of overwritten frames
//
// Build option
//   ADC_REPORT_CHAN_TAG_EN  prefix each field with "<hex channel index>:"
module adc_hex_reporter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4,
    parameter logic [7:0]  SEP    = 8'h2C
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] i_frame,
    input  logic                     i_frame_valid,
    input  logic                     i_error,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     o_busy,
    output logic                     o_dropped,
    output logic [7:0]               o_overrun_cnt
);

    localparam int NumDig = DATA_W / 4;
`ifdef ADC_REPORT_CHAN_TAG_EN
    localparam int TagLen = 2;
`else
    localparam int TagLen = 0;
`endif
    // Field positions 0..FieldLen-1 are tag + digits; position FieldLen is SEP.
    localparam int FieldLen = TagLen + NumDig;
    localparam int ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FrameW   = NUM_CH * DATA_W;
    localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StData, StEol} state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_e            state_q, state_d;
    logic [FrameW-1:0] shadow_q, shadow_d;
    logic [FrameW-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [3:0]        pos_q, pos_d;
    logic              eol_lf_q, eol_lf_d;
    logic              err_line_q, err_line_d;
    logic              err_armed_q, err_armed_d;
    logic              err_prev_q, err_prev_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              dropped_q, dropped_d;
    logic [7:0]        ovr_q, ovr_d;

    logic              issue;
    logic              err_req;
    logic              pend_taken;
    logic              frame_direct;
    logic [DATA_W-1:0] cur_chan;
    logic [3:0]        cur_nib;
    int                dig;
    logic [7:0]        data_byte;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ch_q        <= '0;
            pos_q       <= '0;
            eol_lf_q    <= 1'b0;
            err_line_q  <= 1'b0;
            err_armed_q <= 1'b0;
            err_prev_q  <= 1'b0;  // i_error high out of reset reads as a rising edge
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            dropped_q   <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ch_q        <= ch_d;
            pos_q       <= pos_d;
            eol_lf_q    <= eol_lf_d;
            err_line_q  <= err_line_d;
            err_armed_q <= err_armed_d;
            err_prev_q  <= err_prev_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            dropped_q   <= dropped_d;
            ovr_q       <= ovr_d;
        end
    end

    // Character for the current position of a data line
    always_comb begin
        cur_chan = shadow_q[int'(ch_q) * DATA_W +: DATA_W];
        dig      = int'(pos_q) - TagLen;
        if (dig < 0 || dig >= NumDig) begin
            dig = 0;
        end
        cur_nib = 4'(cur_chan >> (4 * (NumDig - 1 - dig)));

        if (err_line_q) begin
            data_byte = 8'h45;
`ifdef ADC_REPORT_CHAN_TAG_EN
        end else if (pos_q == 4'd0) begin
            data_byte = hex_char(4'(ch_q));
        end else if (pos_q == 4'd1) begin
            data_byte = 8'h3A;
`endif
        end else if (int'(pos_q) < FieldLen) begin
            data_byte = hex_char(cur_nib);
        end else begin
            data_byte = SEP;
        end
    end

    // Next-state logic
    always_comb begin
        // A byte may be issued only if uart_tx is idle and no strobe went out last cycle.
        issue   = (state_q != StIdle) && !tx_busy && !tx_start_q;
        err_req = err_armed_q || (i_error && !err_prev_q);

        state_d      = state_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        ch_d         = ch_q;
        pos_d        = pos_q;
        eol_lf_d     = eol_lf_q;
        err_line_d   = err_line_q;
        err_armed_d  = err_req;
        err_prev_d   = i_error;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        dropped_d    = 1'b0;
        ovr_d        = ovr_q;
        pend_taken   = 1'b0;
        frame_direct = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (err_req) begin
                    // Error report wins; any frame this cycle waits in the pending buffer.
                    err_armed_d = 1'b0;
                    err_line_d  = 1'b1;
                    state_d     = StData;
                end else if (pend_vld_q) begin
                    shadow_d   = pend_q;
                    pend_taken = 1'b1;
                    err_line_d = 1'b0;
                    ch_d       = '0;
                    pos_d      = '0;
                    state_d    = StData;
                end else if (i_frame_valid) begin
                    shadow_d     = i_frame;
                    frame_direct = 1'b1;
                    err_line_d   = 1'b0;
                    ch_d         = '0;
                    pos_d        = '0;
                    state_d      = StData;
                end
            end
            StData: begin
                if (issue) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = data_byte;
                    if (err_line_q) begin
                        eol_lf_d = 1'b0;
                        state_d  = StEol;
                    end else if (int'(pos_q) == FieldLen - 1) begin
                        if (ch_q == LastCh) begin
                            eol_lf_d = 1'b0;
                            state_d  = StEol;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else if (int'(pos_q) == FieldLen) begin
                        pos_d = '0;
                        ch_d  = ch_q + 1'b1;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            StEol: begin
                if (issue) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = eol_lf_q ? 8'h0A : 8'h0D;
                    if (!eol_lf_q) begin
                        eol_lf_d = 1'b1;
                    end else if (!err_req && pend_vld_q) begin
                        // Back-to-back line straight from the pending buffer.
                        shadow_d   = pend_q;
                        pend_taken = 1'b1;
                        err_line_d = 1'b0;
                        ch_d       = '0;
                        pos_d      = '0;
                        eol_lf_d   = 1'b0;
                        state_d    = StData;
                    end else begin
                        // An armed error report is emitted from IDLE.
                        err_line_d = 1'b0;
                        eol_lf_d   = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Pending buffer intake; overwriting a still-occupied buffer is an overrun.
        if (i_frame_valid && !frame_direct) begin
            pend_d     = i_frame;
            pend_vld_d = 1'b1;
            if (pend_vld_q && !pend_taken) begin
                dropped_d = 1'b1;
                if (ovr_q != 8'hFF) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
        end else if (pend_taken) begin
            pend_vld_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        o_busy        = (state_q != StIdle);
        tx_start      = tx_start_q;
        tx_data       = tx_data_q;
        o_dropped     = dropped_q;
        o_overrun_cnt = ovr_q;
    end

endmodule

// File: tb/tb_adc_hex_reporter.sv
// Directed bench for adc_hex_reporter: a default instance (16-bit x 4) and a
// 12-bit x 2 instance, each driven into a uart_tx busy model that stays busy
// for 10 cycles after every start strobe.
module tb_adc_hex_reporter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        err;
    logic        err2;
    logic [63:0] frame0;
    logic        fv0;
    logic [23:0] frame2;
    logic        fv2;
    logic [7:0]  txd0, txd2, ovr0, ovr2;
    logic        txs0, txs2, obusy0, obusy2, drop0, drop2;
    logic        busy0, busy2;
    int          bcnt0, bcnt2;

    adc_hex_reporter dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame       (frame0),
        .i_frame_valid (fv0),
        .i_error       (err),
        .tx_data       (txd0),
        .tx_start      (txs0),
        .tx_busy       (busy0),
        .o_busy        (obusy0),
        .o_dropped     (drop0),
        .o_overrun_cnt (ovr0)
    );

    adc_hex_reporter #(
        .DATA_W (12),
        .NUM_CH (2)
    ) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame       (frame2),
        .i_frame_valid (fv2),
        .i_error       (err2),
        .tx_data       (txd2),
        .tx_start      (txs2),
        .tx_busy       (busy2),
        .o_busy        (obusy2),
        .o_dropped     (drop2),
        .o_overrun_cnt (ovr2)
    );

    // uart_tx busy model
    always @(posedge clk) begin
        if (!rst_n) begin
            bcnt0 <= 0;
            bcnt2 <= 0;
        end else begin
            if (txs0) bcnt0 <= 10;
            else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
            if (txs2) bcnt2 <= 10;
            else if (bcnt2 != 0) bcnt2 <= bcnt2 - 1;
        end
    end
    assign busy0 = (bcnt0 != 0);
    assign busy2 = (bcnt2 != 0);

    // Byte capture and strobe-rule monitor, sampled on the falling edge
    string cap0 = "", cap2 = "";
    int    nb0 = 0, nb2 = 0, drops0 = 0, viol0 = 0, viol2 = 0;
    logic  prev0 = 1'b0, prev2 = 1'b0;

    function automatic string esc(input logic [7:0] b);
        if (b == 8'h0D) return "\\r";
        if (b == 8'h0A) return "\\n";
        return $sformatf("%c", b);
    endfunction

    always @(negedge clk) begin
        if (txs0) begin
            if (busy0 || prev0) viol0++;
            cap0 = {cap0, esc(txd0)};
            nb0++;
        end
        if (txs2) begin
            if (busy2 || prev2) viol2++;
            cap2 = {cap2, esc(txd2)};
            nb2++;
        end
        if (drop0) drops0++;
        prev0 = txs0;
        prev2 = txs2;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input string got, input string exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got '%s' expected '%s'", tag, got, exp);
    endtask

    function automatic string h(input logic [31:0] v);
        return $sformatf("%0h", v);
    endfunction

    task automatic clr();
        cap0 = ""; nb0 = 0; drops0 = 0;
        cap2 = ""; nb2 = 0;
    endtask

    task automatic wait_bytes(input bit sel, input int n, input int budget);
        int c = 0;
        while ((sel ? nb2 : nb0) < n && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        if ((sel ? nb2 : nb0) < n)
            check("timeout", $sformatf("%0d", sel ? nb2 : nb0), $sformatf("%0d", n));
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((obusy0 || busy0 || obusy2 || busy2) && c < 2000) begin
            @(negedge clk); #1;
            c++;
        end
        if (obusy0 || busy0 || obusy2 || busy2) check("idle_timeout", "busy", "idle");
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic send0(input logic [63:0] f);
        frame0 = f;
        fv0    = 1'b1;
        @(negedge clk);
        fv0    = 1'b0;
    endtask

    string s_def, s_f1, s_f3, s_d2, first_chr;
    int    line_len;

    initial begin
`ifdef ADC_REPORT_CHAN_TAG_EN
        s_def     = "0:C3D4,1:1A2B,2:0000,3:7FFF\\r\\n";
        s_f1      = "0:1234,1:0F0F,2:ABCD,3:FFFF\\r\\n";
        s_f3      = "0:0004,1:0003,2:0002,3:0001\\r\\n";
        s_d2      = "0:123,1:ABC\\r\\n";
        first_chr = "30";
        line_len  = 29;
`else
        s_def     = "C3D4,1A2B,0000,7FFF\\r\\n";
        s_f1      = "1234,0F0F,ABCD,FFFF\\r\\n";
        s_f3      = "0004,0003,0002,0001\\r\\n";
        s_d2      = "123,ABC\\r\\n";
        first_chr = "43";
        line_len  = 21;
`endif
        rst_n  = 1'b0;
        err    = 1'b0;
        err2   = 1'b0;
        fv0    = 1'b0;
        fv2    = 1'b0;
        frame0 = '0;
        frame2 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_start", h(txs0), "0");
        check("rst_tx_data", h(txd0), "0");
        check("rst_busy", h(obusy0), "0");
        check("rst_dropped", h(drop0), "0");
        check("rst_ovr", h(ovr0), "0");
        check("rst_busy_d2", h(obusy2), "0");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single line plus first-byte latency
        clr();
        send0({16'h7FFF, 16'h0000, 16'h1A2B, 16'hC3D4});
        check("lat_busy", h(obusy0), "1");
        check("lat_no_start", h(txs0), "0");
        @(negedge clk);
        check("lat_start", h(txs0), "1");
        check("lat_data", h(txd0), first_chr);
        wait_bytes(0, line_len, 1000);
        check("line_default", cap0, s_def);
        wait_idle();
        check("line_pulses", $sformatf("%0d", nb0), $sformatf("%0d", line_len));
        check("line_busy_end", h(obusy0), "0");

        // Three back-to-back frames: F1 shown, F2 overwritten by F3
        clr();
        send0({16'hFFFF, 16'hABCD, 16'h0F0F, 16'h1234});
        send0({16'h5555, 16'h6666, 16'h7777, 16'h8888});
        send0({16'h0001, 16'h0002, 16'h0003, 16'h0004});
        wait_bytes(0, 2 * line_len, 2000);
        wait_idle();
        check("ovr_lines", cap0, {s_f1, s_f3});
        check("ovr_drops", $sformatf("%0d", drops0), "1");
        check("ovr_cnt", h(ovr0), "1");

        // Error rising with a frame: error report first, then the frame
        clr();
        err    = 1'b1;
        frame0 = {16'h7FFF, 16'h0000, 16'h1A2B, 16'hC3D4};
        fv0    = 1'b1;
        @(negedge clk);
        fv0    = 1'b0;
        wait_bytes(0, 3 + line_len, 1500);
        wait_idle();
        check("err_then_line", cap0, {"E\\r\\n", s_def});
        check("err_no_drop", $sformatf("%0d", drops0), "0");

        // i_error still high: no second report
        clr();
        send0({16'hFFFF, 16'hABCD, 16'h0F0F, 16'h1234});
        wait_bytes(0, line_len, 1000);
        wait_idle();
        check("err_held", cap0, s_f1);

        // Low for a cycle, then high again: rearmed
        clr();
        err = 1'b0;
        repeat (2) @(negedge clk);
        err = 1'b1;
        wait_bytes(0, 3, 300);
        repeat (40) @(negedge clk);
        #1;
        check("err_rearm", cap0, "E\\r\\n");
        err = 1'b0;
        wait_idle();

        // Narrow instance: DATA_W=12, NUM_CH=2
        clr();
        frame2 = {12'hABC, 12'h123};
        fv2    = 1'b1;
        @(negedge clk);
        fv2    = 1'b0;
        wait_bytes(1, line_len == 21 ? 9 : 13, 1000);
        wait_idle();
        check("d2_line", cap2, s_d2);

        // Reset after three bytes aborts the line
        clr();
        send0({16'h7FFF, 16'h0000, 16'h1A2B, 16'hC3D4});
        wait_bytes(0, 3, 300);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_start", h(txs0), "0");
        check("abort_busy", h(obusy0), "0");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        check("abort_no_resume", $sformatf("%0d", nb0), "3");
        check("abort_ovr", h(ovr0), "0");
        clr();
        send0({16'hFFFF, 16'hABCD, 16'h0F0F, 16'h1234});
        wait_bytes(0, line_len, 1000);
        wait_idle();
        check("abort_next_line", cap0, s_f1);

        // Frame every cycle for 300 cycles: counter saturates
        for (int i = 0; i < 300; i++) begin
            frame0 = 64'(i);
            fv0    = 1'b1;
            @(negedge clk);
        end
        fv0 = 1'b0;
        check("ovr_sat", h(ovr0), "ff");
        repeat (20) @(negedge clk);
        check("ovr_sat_hold", h(ovr0), "ff");

        check("strobe_rule_d0", $sformatf("%0d", viol0), "0");
        check("strobe_rule_d2", $sformatf("%0d", viol2), "0");
        check("d2_ovr", h(ovr2), "0");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_hex_reporter.md
ADC_HEX_REPORTER -- requirements
Module: adc_hex_reporter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 SHALL have parameter NUM_CH, default 4, channels per frame; legal range 1..8.
REQ-003 SHALL have parameter SEP, default 8'h2C (','), the field separator character.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 i_frame  in  NUM_CH*DATA_W  channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 i_frame_valid  in  1  one-cycle strobe; i_frame is valid in the same cycle.
REQ-008 i_error  in  1  level input; high while the ADC driver reports an error.
REQ-009 tx_data  out  8  ASCII byte sent to uart_tx.
REQ-010 tx_start  out  1  one-cycle start strobe to uart_tx.
REQ-011 tx_busy  in  1  uart_tx busy flag.
REQ-012 o_busy  out  1  high while a line is being emitted.
REQ-013 o_dropped  out  1  one-cycle pulse when a pending frame is overwritten.
REQ-014 o_overrun_cnt  out  8  count of overwritten frames; saturates at 8'hFF.

Function
REQ-015 SHALL use a 3-state FSM: IDLE, DATA, EOL (EOL emits CR then LF).
REQ-016 In IDLE, a captured frame SHALL be latched into a shadow register, and the FSM SHALL move to DATA.
REQ-017 Each channel SHALL be emitted as DATA_W/4 uppercase hex digits, MSB nibble first, in order channel 0 to NUM_CH-1.
REQ-018 SEP SHALL be emitted between fields, with none after the last field.
REQ-019 Every line SHALL end with 8'h0D followed by 8'h0A.
REQ-020 Line length SHALL be NUM_CH*(DATA_W/4) + (NUM_CH-1) + 2 bytes.
REQ-021 tx_start SHALL pulse for exactly one cycle, only in a cycle where tx_busy==0 and tx_start was low in the previous cycle.
REQ-022 tx_data SHALL be stable in the cycle tx_start is high.
REQ-023 Latency: with frame_valid sampled at edge N in IDLE and tx_busy low, tx_start SHALL be high in the cycle after edge N+1.
REQ-024 SHALL provide a one-deep pending buffer. A frame arriving while o_busy is high is stored in the buffer.
REQ-025 On LF issue, a pending frame SHALL be moved to the shadow register and the FSM SHALL go directly to DATA with no IDLE cycle.
REQ-026 A frame arriving while the pending buffer is full SHALL overwrite the buffer (newest data kept), pulse o_dropped, and increment o_overrun_cnt (saturating).
REQ-027 When the LF issue coincides with a new frame_valid, the new frame SHALL become pending and SHALL NOT count as an overrun.
REQ-028 A rising edge of i_error SHALL arm an error report, which emits "E\r\n" once at the next IDLE.
REQ-029 The error report SHALL rearm only after i_error has been low for at least one cycle.
REQ-030 When an error report and a frame are both ready in IDLE, the error report SHALL take priority and the frame SHALL wait in the pending buffer.
REQ-031 The shadow register SHALL NOT change while a line is in progress; each line is generated from one coherent snapshot.

Reset
REQ-032 While rst_n==0 at an edge, the block SHALL set: FSM=IDLE, tx_start=0, tx_data=0, o_busy=0, o_dropped=0, o_overrun_cnt=0, pending buffer empty, error report disarmed, edge detector primed so that i_error high out of reset counts as a rising edge.
REQ-033 Reset asserted mid-line SHALL abort the line at once; no further tx_start pulses SHALL occur, and the partial line SHALL NOT be resumed.

Configuration
REQ-034 Macro ADC_REPORT_CHAN_TAG_EN: when defined, each field SHALL be prefixed by the channel index as one hex digit followed by ':', e.g. "0:1A2B,1:00FF".
REQ-035 With ADC_REPORT_CHAN_TAG_EN defined, line length SHALL increase by 2*NUM_CH bytes.
REQ-036 When ADC_REPORT_CHAN_TAG_EN is undefined, no tag logic SHALL be present and output SHALL be as REQ-017..REQ-020.

Verification
REQ-037 Defaults, frame {16'h7FFF,16'h0000,16'h1A2B,16'hC3D4} (ch0=C3D4), tx_busy model 10 cycles -> bytes "C3D4,1A2B,0000,7FFF\r\n", 21 tx_start pulses, none while busy.
REQ-038 Three frames F1,F2,F3 one cycle apart in IDLE -> F1 line then F3 line; o_dropped pulses once; o_overrun_cnt=1.
REQ-039 i_error rises in the same cycle as frame_valid in IDLE -> "E\r\n" then the frame line; i_error held high -> no second "E".
REQ-040 DATA_W=12, NUM_CH=2, frame {12'hABC,12'h123} -> "123,ABC\r\n".
REQ-041 rst_n low after 3 bytes of a line -> tx_start low from the next cycle; o_overrun_cnt=0; next frame produces a complete line.
REQ-042 ADC_REPORT_CHAN_TAG_EN defined, NUM_CH=2, frame {16'h0001,16'hFFFF} -> "0:FFFF,1:0001\r\n"; 260 forced overruns -> o_overrun_cnt=8'hFF.
